// File: rtl/ifm_feeder.sv
// ifm_feeder: streams a signed 8-bit IMG_W x IMG_H IFM tile from the IFM SRAM, row-major, into the 3-tap shift buffer.
// Latency: first ifm_read two clock edges after the accepted start, then one byte per unstalled cycle with no bubbles.
// Backpressure: shared stall freezes issue and the output register; the single in-flight read lands in a 1-entry skid.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   stall                  global pipeline stall, same net the shift buffer sees
//   start, base_addr       one-cycle start pulse (IDLE only) and SRAM address of pixel (0,0)
//   busy, done             tile in progress / one-cycle pulse after the last byte transfers
//   sram_en, sram_addr     SRAM read request; sram_rdata returns exactly one cycle later
//   ifm_input, ifm_read    registered byte and shift strobe; a byte moves when ifm_read=1 and stall=0
//
// Build option: define IFM_FEEDER_ZERO_PAD_EN to wrap the tile in a 1-pixel zero border,
// emitting (IMG_W+2)x(IMG_H+2) bytes. Left undefined, no pad logic exists.

module ifm_feeder #(
  parameter int ADDR_W = 12,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                sram_en,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic [7:0]          sram_rdata,
  output logic signed [7:0]   ifm_input,
  output logic                ifm_read
);

`ifdef IFM_FEEDER_ZERO_PAD_EN
  localparam int COLS = IMG_W + 2;
  localparam int ROWS = IMG_H + 2;
`else
  localparam int COLS = IMG_W;
  localparam int ROWS = IMG_H;
`endif

  // One spare count so the row counter can step past the last row without overflow.
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              skid_vld_q, skid_vld_d;
  logic [7:0]        skid_dat_q, skid_dat_d;
  logic              ifm_vld_q, ifm_vld_d;
  logic [7:0]        ifm_dat_q, ifm_dat_d;
`ifdef IFM_FEEDER_ZERO_PAD_EN
  logic              pad_pend_q, pad_pend_d;
  logic              border;
`endif

  logic              issue;
  logic              last_pos;
  logic              drain_done;
  logic [7:0]        rd_byte;

  // Issue stage. Every position (border or interior) takes one issue slot so that
  // border zeros travel down the same two-stage pipe as SRAM bytes and keep order.
  // The skid can only be full on the first unstalled cycle after a stall, and it
  // empties into the output register on that very cycle, so gating issue on stall
  // alone never lets a second read collide with a held skid byte.
  always_comb begin
    issue    = (state_q == S_ISSUE) && !stall;
    last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
`ifdef IFM_FEEDER_ZERO_PAD_EN
    border   = (row_q == '0) || (row_q == ROW_LAST) ||
               (col_q == '0) || (col_q == COL_LAST);
    sram_en  = issue && !border;
    rd_byte  = pad_pend_q ? 8'h00 : sram_rdata;
`else
    sram_en  = issue;
    rd_byte  = sram_rdata;
`endif
  end

  // The final byte is the one sitting in the output register with nothing behind it.
  always_comb begin
    drain_done = (state_q == S_DRAIN) && !rd_pend_q && !skid_vld_q &&
                 ifm_vld_q && !stall;
  end

  // Control FSM and position/address counters.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
          ptr_d   = base_addr;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          // Interior pixels are consecutive in SRAM, so a pointer replaces row*IMG_W+col.
          if (sram_en) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (last_pos) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Return path: read data (or pad zero) arrives one cycle after issue. While stalled
  // the output register holds, so the returning byte parks in the skid; on release
  // the skid byte goes out first, ahead of anything issued later.
  always_comb begin
    rd_pend_d  = issue;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    ifm_vld_d  = ifm_vld_q;
    ifm_dat_d  = ifm_dat_q;
`ifdef IFM_FEEDER_ZERO_PAD_EN
    pad_pend_d = issue && border;
`endif
    if (stall) begin
      if (rd_pend_q) begin
        skid_vld_d = 1'b1;
        skid_dat_d = rd_byte;
      end
    end else if (skid_vld_q) begin
      ifm_vld_d  = 1'b1;
      ifm_dat_d  = skid_dat_q;
      skid_vld_d = 1'b0;
    end else if (rd_pend_q) begin
      ifm_vld_d  = 1'b1;
      ifm_dat_d  = rd_byte;
    end else begin
      ifm_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      ptr_q      <= '0;
      rd_pend_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      ifm_vld_q  <= 1'b0;
      ifm_dat_q  <= '0;
`ifdef IFM_FEEDER_ZERO_PAD_EN
      pad_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      ifm_vld_q  <= ifm_vld_d;
      ifm_dat_q  <= ifm_dat_d;
`ifdef IFM_FEEDER_ZERO_PAD_EN
      pad_pend_q <= pad_pend_d;
`endif
    end
  end

  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign sram_addr = ptr_q;
  assign ifm_input = ifm_dat_q;
  assign ifm_read  = ifm_vld_q;

endmodule

// File: tb/tb_ifm_feeder.sv
module tb_ifm_feeder;

`ifdef IFM_FEEDER_ZERO_PAD_EN
  localparam int PAD = 1;
  localparam logic [7:0] HOLD_EXP = 8'h00;
`else
  localparam int PAD = 0;
  localparam logic [7:0] HOLD_EXP = 8'h13;
`endif
  localparam int N_A   = (4 + 2 * PAD) * (3 + 2 * PAD);
  localparam int N_B   = (2 + 2 * PAD) * (2 + 2 * PAD);
  localparam int INT_A = 12;
  localparam int INT_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [11:0] base_a = '0, base_b = '0;

  logic        a_busy, a_done, a_sram_en, a_ifm_read;
  logic [11:0] a_sram_addr;
  logic [7:0]  a_rdata = '0;
  logic signed [7:0] a_ifm_input;
  logic        b_busy, b_done, b_sram_en, b_ifm_read;
  logic [11:0] b_sram_addr;
  logic [7:0]  b_rdata = '0;
  logic signed [7:0] b_ifm_input;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int a_xfers = 0, a_dones = 0, a_en = 0, a_last_cyc = 0;
  int b_xfers = 0, b_dones = 0, b_en = 0, b_last_cyc = 0;
  logic [7:0]  exp_a[$], exp_b[$];
  logic [11:0] adr_a[$], adr_b[$];

  ifm_feeder #(.ADDR_W(12), .IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .start(start_a), .base_addr(base_a),
    .busy(a_busy), .done(a_done), .sram_en(a_sram_en), .sram_addr(a_sram_addr),
    .sram_rdata(a_rdata), .ifm_input(a_ifm_input), .ifm_read(a_ifm_read)
  );

  ifm_feeder #(.ADDR_W(12), .IMG_W(2), .IMG_H(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .start(start_b), .base_addr(base_b),
    .busy(b_busy), .done(b_done), .sram_en(b_sram_en), .sram_addr(b_sram_addr),
    .sram_rdata(b_rdata), .ifm_input(b_ifm_input), .ifm_read(b_ifm_read)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: byte at address a is a[7:0], returned one cycle after the read.
  always @(posedge clk) if (a_sram_en) a_rdata <= a_sram_addr[7:0];
  always @(posedge clk) if (b_sram_en) b_rdata <= b_sram_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: pop expected byte on each transfer, expected address on each read.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_ifm_read === 1'b1 && stall === 1'b0) begin
        a_xfers++;
        a_last_cyc = cyc;
        n_cmp++;
        assert (exp_a.size() != 0) else begin
          n_bad++;
          $error("FAIL a_extra_xfer: observed byte 0x%0h expected no transfer", a_ifm_input);
        end
        if (exp_a.size() != 0) chk("a_byte", 32'($unsigned(a_ifm_input)), 32'(exp_a.pop_front()));
      end
      if (a_sram_en === 1'b1) begin
        a_en++;
        if (adr_a.size() != 0) chk("a_addr", 32'(a_sram_addr), 32'(adr_a.pop_front()));
      end
      if (a_done === 1'b1) a_dones++;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b_ifm_read === 1'b1 && stall === 1'b0) begin
        b_xfers++;
        b_last_cyc = cyc;
        n_cmp++;
        assert (exp_b.size() != 0) else begin
          n_bad++;
          $error("FAIL b_extra_xfer: observed byte 0x%0h expected no transfer", b_ifm_input);
        end
        if (exp_b.size() != 0) chk("b_byte", 32'($unsigned(b_ifm_input)), 32'(exp_b.pop_front()));
      end
      if (b_sram_en === 1'b1) begin
        b_en++;
        if (adr_b.size() != 0) chk("b_addr", 32'(b_sram_addr), 32'(adr_b.pop_front()));
      end
      if (b_done === 1'b1) b_dones++;
    end
  end

  // Reference stream: row-major, optional zero border, interior bytes = address[7:0].
  task automatic push_tile(input bit b, input logic [11:0] base);
    logic [11:0] a;
    int rows, cols;
    bit border;
    a    = base;
    cols = (b ? 2 : 4) + 2 * PAD;
    rows = (b ? 2 : 3) + 2 * PAD;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        border = (PAD == 1) && (r == 0 || r == rows - 1 || c == 0 || c == cols - 1);
        if (border) begin
          if (b) exp_b.push_back(8'h00); else exp_a.push_back(8'h00);
        end else begin
          if (b) begin exp_b.push_back(a[7:0]); adr_b.push_back(a); end
          else   begin exp_a.push_back(a[7:0]); adr_a.push_back(a); end
          a = a + 12'd1;
        end
      end
    end
  endtask

  // Pulses start; acc is the cycle index of the first cycle after the accepting edge.
  task automatic do_start(input bit b, input logic [11:0] base, output int acc);
    @(posedge clk); #1;
    if (b) begin start_b = 1'b1; base_b = base; end
    else   begin start_a = 1'b1; base_a = base; end
    push_tile(b, base);
    acc = cyc + 1;
    @(negedge clk);
    chk(b ? "b_busy_before_accept" : "a_busy_before_accept", 32'(b ? b_busy : a_busy), 32'd0);
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // kind 0: first ifm_read, kind 1: done. Bounded; a timeout is a failed comparison.
  task automatic wait_evt(input bit b, input bit kind, output int c);
    logic s;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s = kind ? (b ? b_done : a_done) : (b ? b_ifm_read : a_ifm_read);
      if (s === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk(kind ? "done_seen_in_budget" : "read_seen_in_budget", 32'(c >= 0), 32'd1);
  endtask

  task automatic finish_tile(input bit b, input string tag, input int first, input int extra,
                             input int x0, input int d0, input int e0);
    int dn, last;
    wait_evt(b, 1'b1, dn);
    @(negedge clk); #1;
    last = b ? b_last_cyc : a_last_cyc;
    chk({tag, "_done_one_cycle"}, 32'(b ? b_done : a_done), 32'd0);
    chk({tag, "_last_xfer_cyc"}, 32'(last), 32'(first + (b ? N_B : N_A) - 1 + extra));
    chk({tag, "_done_after_last"}, 32'(dn), 32'(last + 1));
    chk({tag, "_xfer_count"}, 32'((b ? b_xfers : a_xfers) - x0), 32'(b ? N_B : N_A));
    chk({tag, "_done_count"}, 32'((b ? b_dones : a_dones) - d0), 32'd1);
    chk({tag, "_sram_en_count"}, 32'((b ? b_en : a_en) - e0), 32'(b ? INT_B : INT_A));
    chk({tag, "_queue_drained"}, 32'(b ? exp_b.size() : exp_a.size()), 32'd0);
    chk({tag, "_busy_after"}, 32'(b ? b_busy : a_busy), 32'd0);
  endtask

  initial begin
    int acc, first, x0, d0, e0;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_sram_en", 32'(a_sram_en), 32'd0);
    chk("rst_sram_addr", 32'(a_sram_addr), 32'd0);
    chk("rst_ifm_input", 32'($unsigned(a_ifm_input)), 32'd0);
    chk("rst_ifm_read", 32'(a_ifm_read), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // T1: plain 4x3 tile from 0x010
    x0 = a_xfers; d0 = a_dones; e0 = a_en;
    do_start(1'b0, 12'h010, acc);
    wait_evt(1'b0, 1'b0, first);
    chk("t1_first_read_latency", 32'(first), 32'(acc + 2));
    finish_tile(1'b0, "t1", first, 0, x0, d0, e0);

    // T2: 3-cycle stall starting right after 0x014 is issued
    x0 = a_xfers; d0 = a_dones; e0 = a_en;
    do_start(1'b0, 12'h010, acc);
    wait_evt(1'b0, 1'b0, first);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_sram_en === 1'b1 && a_sram_addr === 12'h014) begin seen = 1'b1; break; end
    end
    chk("t2_issue_0x14_seen", 32'(seen), 32'd1);
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_ifm_input", 32'($unsigned(a_ifm_input)), 32'(HOLD_EXP));
      chk("t2_hold_ifm_read", 32'(a_ifm_read), 32'd1);
      chk("t2_no_issue_in_stall", 32'(a_sram_en), 32'd0);
    end
    @(posedge clk); #1 stall = 1'b0;
    finish_tile(1'b0, "t2", first, 3, x0, d0, e0);

    // T3: reset after 5 transfers, then a fresh tile
    x0 = a_xfers; d0 = a_dones;
    do_start(1'b0, 12'h010, acc);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (a_xfers - x0 >= 5) begin seen = 1'b1; break; end
    end
    chk("t3_five_xfers_seen", 32'(seen), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t3_abort_busy", 32'(a_busy), 32'd0);
    chk("t3_abort_sram_en", 32'(a_sram_en), 32'd0);
    chk("t3_abort_sram_addr", 32'(a_sram_addr), 32'd0);
    chk("t3_abort_ifm_input", 32'($unsigned(a_ifm_input)), 32'd0);
    chk("t3_abort_ifm_read", 32'(a_ifm_read), 32'd0);
    chk("t3_abort_done", 32'(a_done), 32'd0);
    repeat (2) @(posedge clk);
    exp_a.delete();
    adr_a.delete();
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_no_done_from_abort", 32'(a_dones - d0), 32'd0);
    x0 = a_xfers; d0 = a_dones; e0 = a_en;
    do_start(1'b0, 12'h010, acc);
    wait_evt(1'b0, 1'b0, first);
    chk("t3_first_read_latency", 32'(first), 32'(acc + 2));
    finish_tile(1'b0, "t3", first, 0, x0, d0, e0);

    // T4: start pulsed while busy is ignored
    x0 = a_xfers; d0 = a_dones; e0 = a_en;
    do_start(1'b0, 12'h010, acc);
    wait_evt(1'b0, 1'b0, first);
    @(posedge clk); #1 start_a = 1'b1; base_a = 12'h100;
    @(posedge clk); #1 start_a = 1'b0;
    finish_tile(1'b0, "t4", first, 0, x0, d0, e0);
    repeat (5) @(negedge clk);
    chk("t4_single_done", 32'(a_dones - d0), 32'd1);
    chk("t4_no_extra_xfers", 32'(a_xfers - x0), 32'(N_A));

    // T5: stall high in IDLE; start still accepted, issue waits for release
    x0 = a_xfers; d0 = a_dones; e0 = a_en;
    @(posedge clk); #1 stall = 1'b1;
    do_start(1'b0, 12'h010, acc);
    @(negedge clk);
    chk("t5_busy_under_stall", 32'(a_busy), 32'd1);
    chk("t5_sram_en_under_stall", 32'(a_sram_en), 32'd0);
    @(posedge clk); #1 stall = 1'b0;
    wait_evt(1'b0, 1'b0, first);
    chk("t5_first_read_latency", 32'(first), 32'(acc + 3));
    finish_tile(1'b0, "t5", first, 0, x0, d0, e0);

    // T6: 2x2 tile at 0xFFE, address wrap
    x0 = b_xfers; d0 = b_dones; e0 = b_en;
    do_start(1'b1, 12'hFFE, acc);
    wait_evt(1'b1, 1'b0, first);
    chk("t6_first_read_latency", 32'(first), 32'(acc + 2));
    finish_tile(1'b1, "t6", first, 0, x0, d0, e0);

    // T7: 2x2 tile with data 1,2,3,4
    x0 = b_xfers; d0 = b_dones; e0 = b_en;
    do_start(1'b1, 12'h001, acc);
    wait_evt(1'b1, 1'b0, first);
    finish_tile(1'b1, "t7", first, 0, x0, d0, e0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
